// File: rtl/net_share_arbiter_pkg.sv
// Shared state encoding and width helpers for the round-robin net-sharing arbiter.
package net_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } arb_state_t;

    // Index width never drops below one bit, even for a two-requester share.
    function automatic int IDX_W(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int CNT_W(input int max_hold);
        return $clog2(max_hold + 1);
    endfunction

    // Reset value of the round-robin pointer: points at the top index so index 0 wins first.
    function automatic int LAST_OWNER_RST(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/net_share_arbiter_if.sv
// Requester-side and shared-bus signals of the net-sharing arbiter.
interface net_share_arbiter_if
    import net_arb_pkg::*;
#(
    parameter int N_REQ  = 20,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]         req;
    logic [N_REQ-1:0]         last;
    logic [N_REQ*DATA_W-1:0]  wdata;
    logic [N_REQ-1:0]         gnt;
    logic                     bus_valid;
    logic [DATA_W-1:0]        bus_data;
    logic [IDX_W(N_REQ)-1:0]  bus_owner;
    logic                     timeout;

    modport master (
        output req, last, wdata,
        input  gnt, bus_valid, bus_data, bus_owner, timeout
    );

    modport slave (
        input  req, last, wdata,
        output gnt, bus_valid, bus_data, bus_owner, timeout
    );

endinterface

// File: rtl/net_share_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set req bit at or after start, wrapping at N.
module rr_pick
    import net_arb_pkg::*;
#(
    parameter int N = 20
) (
    input  logic [N-1:0]         req,
    input  logic [IDX_W(N)-1:0]  start,
    output logic                 any,
    output logic [IDX_W(N)-1:0]  idx,
    output logic [N-1:0]         onehot
);
    localparam int IW = IDX_W(N);

    logic [IW:0]   pos;
    logic [IW-1:0] j;

    always_comb begin
        any    = 1'b0;
        idx    = '0;
        onehot = '0;
        pos    = '0;
        j      = '0;
        for (int i = 0; i < N; i++) begin
            pos = {1'b0, start} + (IW+1)'(i);
            if (pos >= (IW+1)'(N)) begin
                pos = pos - (IW+1)'(N);
            end
            j = pos[IW-1:0];
            if (!any && req[j]) begin
                any       = 1'b1;
                idx       = j;
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/net_share_arbiter.sv
// Round-robin owner of one shared net: grant 1 cycle after req, bus outputs 1 cycle behind each beat.
// No backpressure: an owner streams while req is high, bounded by MAX_HOLD, then one idle turnaround cycle.
module net_share_arbiter
    import net_arb_pkg::*;
#(
    parameter int N_REQ    = 20,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 15
) (
    input  logic clk,
    input  logic rst,
    net_share_arbiter_if.slave bus
);
    localparam int IW = IDX_W(N_REQ);
    localparam int CW = CNT_W(MAX_HOLD);

    arb_state_t state, state_nxt;

    logic [IW-1:0]     last_owner;
    logic [IW-1:0]     owner_q;
    logic [IW-1:0]     start_idx;
    logic [IW-1:0]     win_idx;
    logic [N_REQ-1:0]  win_oh;
    logic              win_any;
    logic [CW-1:0]     hold_cnt;
    logic [N_REQ-1:0]  gnt_q;
    logic              bus_valid_q;
    logic [DATA_W-1:0] bus_data_q;
    logic              timeout_q;

    logic              grant;
    logic              beat;
    logic              hold_hit;
    logic              own_req;
    logic              own_last;
    logic [DATA_W-1:0] own_data;
    logic [DATA_W-1:0] slice [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            slice[i] = bus.wdata[i*DATA_W +: DATA_W];
        end
    end

    assign own_req   = bus.req[last_owner];
    assign own_last  = bus.last[last_owner];
    assign own_data  = slice[last_owner];
    assign start_idx = (last_owner == IW'(N_REQ - 1)) ? '0 : last_owner + IW'(1);

    rr_pick #(.N(N_REQ)) u_pick (
        .req    (bus.req),
        .start  (start_idx),
        .any    (win_any),
        .idx    (win_idx),
        .onehot (win_oh)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A dropped req wins over last, and last wins over the hold limit.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        beat      = 1'b0;
        hold_hit  = 1'b0;
        case (state)
            IDLE, TURN: begin
                if (win_any) begin
                    state_nxt = OWN;
                    grant     = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            OWN: begin
                if (!own_req) begin
                    state_nxt = TURN;
                end else begin
                    beat = 1'b1;
                    if (own_last) begin
                        state_nxt = TURN;
                    end else if (hold_cnt == CW'(MAX_HOLD)) begin
                        state_nxt = TURN;
                        hold_hit  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q       <= '0;
            bus_valid_q <= 1'b0;
            bus_data_q  <= '0;
            owner_q     <= '0;
            timeout_q   <= 1'b0;
            hold_cnt    <= '0;
            last_owner  <= IW'(LAST_OWNER_RST(N_REQ));
        end else begin
            bus_valid_q <= beat;
            timeout_q   <= hold_hit;
            if (beat) begin
                bus_data_q <= own_data;
            end
            if (grant) begin
                gnt_q      <= win_oh;
                last_owner <= win_idx;
                owner_q    <= win_idx;
                hold_cnt   <= CW'(1);
            end else if (state == OWN) begin
                if (state_nxt == OWN) begin
                    hold_cnt <= hold_cnt + CW'(1);
                end else begin
                    gnt_q <= '0;
                end
            end
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.bus_valid = bus_valid_q;
    assign bus.bus_data  = bus_data_q;
    assign bus.bus_owner = owner_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_net_share_arbiter.sv
// Directed scoreboard bench for net_share_arbiter plus a small-configuration random soak.
module tb_net_share_arbiter;

    localparam int N  = 20;
    localparam int DW = 8;
    localparam int MH = 15;

    typedef struct packed {
        logic          v;
        logic [DW-1:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    net_share_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();
    net_share_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_HOLD(MH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    net_share_arbiter_if #(.N_REQ(4), .DATA_W(DW)) sbus ();
    net_share_arbiter #(.N_REQ(4), .DATA_W(DW), .MAX_HOLD(3)) dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (sbus.slave)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] bit_of(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic rnd_wdata();
        for (int i = 0; i < N; i++) begin
            bus.wdata[i*DW +: DW] = DW'($urandom);
        end
    endtask

    // Holds rst over one edge, checks the cleared outputs, and primes the scoreboard.
    task automatic do_reset(input string tag);
        exp_t e;
        rst      = 1'b1;
        bus.req  = '0;
        bus.last = '0;
        cyc();
        rst = 1'b0;
        chk({tag, ".gnt"},       32'(bus.gnt),       32'd0);
        chk({tag, ".bus_valid"}, 32'(bus.bus_valid), 32'd0);
        chk({tag, ".bus_data"},  32'(bus.bus_data),  32'd0);
        chk({tag, ".bus_owner"}, 32'(bus.bus_owner), 32'd0);
        chk({tag, ".timeout"},   32'(bus.timeout),   32'd0);
        sb.delete();
        e.v = 1'b0;
        e.d = '0;
        sb.push_back(e);
    endtask

    // Checks this cycle's outputs, then queues the bus beat expected from this cycle's inputs.
    task automatic step(input logic [N-1:0] eg, input logic eb, input logic et, input string tag);
        exp_t e;
        exp_t n;
        chk({tag, ".gnt"},     32'(bus.gnt),     32'(eg));
        chk({tag, ".timeout"}, 32'(bus.timeout), 32'(et));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, ".bus_valid"}, 32'(bus.bus_valid), 32'(e.v));
            if (e.v) begin
                chk({tag, ".bus_data"}, 32'(bus.bus_data), 32'(e.d));
            end
        end else begin
            chk({tag, ".sb_depth"}, 32'(sb.size()), 32'd1);
        end
        rnd_wdata();
        n.v = eb;
        n.d = '0;
        for (int i = 0; i < N; i++) begin
            if (eg[i]) n.d = bus.wdata[i*DW +: DW];
        end
        sb.push_back(n);
        cyc();
    endtask

    initial begin
        int           owners [4];
        logic [3:0]   g;
        logic [3:0]   prev;
        int           grun;
        int           vrun;

        rst        = 1'b1;
        rst2       = 1'b1;
        bus.req    = '0;
        bus.last   = '0;
        bus.wdata  = '0;
        sbus.req   = '0;
        sbus.last  = '0;
        sbus.wdata = '0;
        cyc();

        // Single requester held with last=0: hold limit, timeout, turnaround, regrant.
        do_reset("rst0");
        bus.req = bit_of(0);
        step('0, 1'b0, 1'b0, "s1.idle");
        for (int b = 0; b < MH; b++) begin
            step(bit_of(0), 1'b1, 1'b0, "s1.own");
        end
        step('0, 1'b0, 1'b1, "s1.turn");
        step(bit_of(0), 1'b1, 1'b0, "s1.regrant");
        bus.req = '0;
        step(bit_of(0), 1'b0, 1'b0, "s1.drop");
        step('0, 1'b0, 1'b0, "s1.turn2");
        step('0, 1'b0, 1'b0, "s1.idle2");

        // Three requesters, last on the 3rd beat; non-owner last bits held high.
        do_reset("rst1");
        owners  = '{0, 5, 19, 0};
        bus.req = bit_of(0) | bit_of(5) | bit_of(19);
        step('0, 1'b0, 1'b0, "s2.idle");
        for (int k = 0; k < 4; k++) begin
            for (int b = 1; b <= 3; b++) begin
                bus.last = (b == 3) ? '1 : ~bit_of(owners[k]);
                step(bit_of(owners[k]), 1'b1, 1'b0, "s2.own");
            end
            bus.last = '0;
            if (k == 3) bus.req = '0;
            step('0, 1'b0, 1'b0, "s2.turn");
        end
        step('0, 1'b0, 1'b0, "s2.idle2");

        // req and last together in the first grant cycle: a single beat.
        bus.req  = bit_of(7);
        bus.last = bit_of(7);
        step('0, 1'b0, 1'b0, "s3.idle");
        step(bit_of(7), 1'b1, 1'b0, "s3.own");
        bus.req  = '0;
        bus.last = '0;
        step('0, 1'b0, 1'b0, "s3.turn");
        chk("s3.bus_owner", 32'(bus.bus_owner), 32'd7);
        step('0, 1'b0, 1'b0, "s3.idle2");

        // Owner 3 drops after 4 beats; pending 2 wins after the search wraps.
        bus.req = bit_of(3);
        step('0, 1'b0, 1'b0, "s4.idle");
        step(bit_of(3), 1'b1, 1'b0, "s4.own");
        bus.req = bit_of(3) | bit_of(2);
        for (int b = 0; b < 3; b++) begin
            step(bit_of(3), 1'b1, 1'b0, "s4.own");
        end
        bus.req = bit_of(2);
        step(bit_of(3), 1'b0, 1'b0, "s4.drop");
        step('0, 1'b0, 1'b0, "s4.turn");
        bus.last = bit_of(2);
        step(bit_of(2), 1'b1, 1'b0, "s4.own2");
        bus.req  = '0;
        bus.last = '0;
        step('0, 1'b0, 1'b0, "s4.turn2");
        chk("s4.bus_owner", 32'(bus.bus_owner), 32'd2);
        step('0, 1'b0, 1'b0, "s4.idle2");

        // Reset during beat 6 of owner 10; afterwards index 0 has priority again.
        bus.req = bit_of(10);
        step('0, 1'b0, 1'b0, "s5.idle");
        for (int b = 0; b < 5; b++) begin
            step(bit_of(10), 1'b1, 1'b0, "s5.own");
        end
        rst = 1'b1;
        step(bit_of(10), 1'b0, 1'b0, "s5.rst");
        rst     = 1'b0;
        bus.req = bit_of(10) | bit_of(0);
        chk("s5.bus_data",  32'(bus.bus_data),  32'd0);
        chk("s5.bus_owner", 32'(bus.bus_owner), 32'd0);
        step('0, 1'b0, 1'b0, "s5.after");
        step(bit_of(0), 1'b1, 1'b0, "s5.own0");
        bus.req = '0;
        step(bit_of(0), 1'b0, 1'b0, "s5.drop0");
        step('0, 1'b0, 1'b0, "s5.turn");
        step('0, 1'b0, 1'b0, "s5.idle2");
        chk("s5.sb_drained", 32'(sb.size()), 32'd1);

        // Random soak on the 4-requester, MAX_HOLD=3 instance.
        rst2 = 1'b0;
        cyc();
        prev = '0;
        grun = 0;
        vrun = 0;
        for (int c = 0; c < 600; c++) begin
            sbus.req   = 4'($urandom_range(0, 15));
            sbus.last  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            sbus.wdata = 32'($urandom);
            cyc();
            g = sbus.gnt;
            chk("soak.onehot0", 32'($onehot0(g)), 32'd1);
            chk("soak.switch", 32'((prev != 4'd0) && (g != 4'd0) && (g != prev)), 32'd0);
            if (g != 4'd0) begin
                grun = (g == prev) ? grun + 1 : 1;
                chk("soak.tenure", 32'(grun <= 3), 32'd1);
            end else begin
                grun = 0;
            end
            vrun = sbus.bus_valid ? vrun + 1 : 0;
            if (sbus.bus_valid) begin
                chk("soak.beats", 32'(vrun <= 3), 32'd1);
            end
            prev = g;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
